axis_poly_fifo_writer: RTL
==========================

Name: axis_poly_fifo_writer

Overview:
- Producer end of the global poly FIFO write protocol. Accepts AXI-stream poly lines from the DMA conversion layer and drives one FIFO source port: addrA/addrB, dA/dB, wr_enable, wr_finish. It observes the FIFO's full flag.
- Lines are paired so that two lines are written per cycle. The wr_finish framing is generated so that the FIFO write pointer advances exactly once per poly.

Parameters:
- POLY_LINES, default 2**`ADDR_WIDTH: lines per poly. Must be even and at least 4.
- CNT_WIDTH, default 16: width of the completed-poly counter.
- Line width is fixed by `BIT_WIDTH*`LINE_SIZE (LW below). Address width is fixed by `ADDR_WIDTH (AW below).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  stream line valid.
- s_ready  out  1  stream line accepted when s_valid&s_ready.
- s_data  in  LW  poly line; line 0 arrives first.
- s_last  in  1  marks the final line of a poly.
- fifo_full  in  1  FIFO full flag.
- fifo_addrA  out  AW  even line address 2k.
- fifo_addrB  out  AW  odd line address 2k+1.
- fifo_dA  out  LW  even line data.
- fifo_dB  out  LW  odd line data.
- fifo_wr_enable  out  1  write strobe, one cycle per pair.
- fifo_wr_finish  out  1  low while a poly is being written; high when idle.
- busy  out  1  state != IDLE.
- poly_count  out  CNT_WIDTH  polys completed; wraps modulo 2**CNT_WIDTH.
- err_last  out  1  sticky s_last framing error.

Behaviour:
- Reset values: s_ready=0, fifo_wr_enable=0, fifo_wr_finish=1, fifo_addrA/B=0, fifo_dA/dB=0, busy=0, poly_count=0, err_last=0, line_cnt=0, state=IDLE.
- Reset mid-poly abandons the partial poly. wr_finish returns to 1 on the next edge; no pointer-advance pulse is owed to the FIFO, because the FIFO is reset alongside.
- All fifo_* outputs are registered. s_ready is a combinational decode of state.
- States:
  - IDLE: s_ready=0, wr_finish=1. If s_valid && !fifo_full, go to FILL and drive wr_finish=0 from the next cycle. If fifo_full, stay in IDLE indefinitely.
  - FILL: s_ready=1, wr_finish=0. On each handshake, line_cnt increments.
    - Even line_cnt: capture s_data into the hold register.
    - Odd line_cnt: next cycle wr_enable=1, addrA=line_cnt-1, addrB=line_cnt, dA=hold, dB=s_data.
    - Handshake with line_cnt==POLY_LINES-1: go to LAST.
  - LAST: s_ready=0, wr_finish=0. The final pair write is on the outputs in this cycle. Next state is DONE.
  - DONE: wr_finish=1 (FIFO advances its write pointer at the end of this cycle), poly_count+1, line_cnt=0. Next state is IDLE.
- IDLE samples fifo_full one cycle after DONE, so it sees the updated flag.
- Minimum gap between polys: 2 cycles with wr_finish=1 (DONE, IDLE). Throughput otherwise: POLY_LINES+3 cycles per poly at full valid.
- wr_enable is 0 in every cycle without a pair write. Addr/data hold their last values when wr_enable=0.
- Stalls: s_valid low in FILL only pauses; wr_finish stays 0 and no write is issued.
- Framing:
  - err_last is set if s_last=1 on an accepted line with line_cnt!=POLY_LINES-1.
  - err_last is also set if s_last=0 on the line with line_cnt==POLY_LINES-1.
  - Framing is always by line_cnt, never by s_last; err_last clears only on rst.
- fifo_full asserting during FILL is a protocol violation upstream and is ignored, since full can only rise after DONE.

Decomposition:
- In common.vh / shared package: typedef enum logic [1:0] {WIDLE, WFILL, WLAST, WDONE} axis_wr_states; `BIT_WIDTH, `LINE_SIZE, `ADDR_WIDTH, `SD already exist there.
- No sub-module: the hold register plus pair logic is inline.
- A thin wrapper, myFIFO_source_axis_bridge, maps the fifo_* ports onto the myFIFO_NTT_source_if.to_source modport and wr_enable port.

Test Plan:
- POLY_LINES=8, FIFO empty, 8 back-to-back lines 0x10..0x17 with s_last on line 7 -> wr_enable pulses with (addrA,addrB,dA,dB) = (0,1,0x10,0x11), (2,3,0x12,0x13), (4,5,0x14,0x15), (6,7,0x16,0x17). wr_finish is low for 9 cycles, high in DONE; poly_count=1; FIFO readback matches.
- Stream 4 polys into a depth-4 FIFO with no reads, 5th poly valid -> after 4 DONEs fifo_full=1; writer holds IDLE with s_ready=0 and wr_finish=1. Pop one poly -> 5th poly accepted, poly_count=5.
- Random s_valid gaps (50% duty) -> writes identical to the first test; no wr_enable in stall cycles; wr_finish is never high mid-poly.
- s_last on line 3, and separately no s_last on line 7 -> err_last=1 (sticky); the poly still completes after 8 lines; poly_count increments.
- rst asserted after line 5 accepted -> next cycle s_ready=0, wr_finish=1, wr_enable=0, line_cnt=0; a fresh poly after reset writes from address 0.
- poly_count at 0xFFFF plus one poly -> wraps to 0x0000.

Source files
------------

// File: rtl/axis_poly_fifo_writer_pkg.sv
// rtl/axis_poly_fifo_writer_pkg.sv - shared widths and writer state encoding for the poly FIFO writer
package axis_poly_fifo_writer_pkg;
   localparam int BIT_WIDTH  = 8;
   localparam int LINE_SIZE  = 2;
   localparam int ADDR_WIDTH = 3;
   localparam int LW         = BIT_WIDTH * LINE_SIZE;

   typedef enum logic [1:0] {WIDLE, WFILL, WLAST, WDONE} axis_wr_states;
endpackage

// File: rtl/axis_poly_fifo_writer.sv
// rtl/axis_poly_fifo_writer.sv - AXI-stream poly lines to paired FIFO writes with per-poly wr_finish framing
module axis_poly_fifo_writer
   import axis_poly_fifo_writer_pkg::*;
#(
   parameter int POLY_LINES = 2**ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [LW-1:0]         s_data,
   input  logic                  s_last,
   input  logic                  fifo_full,
   output logic [ADDR_WIDTH-1:0] fifo_addrA,
   output logic [ADDR_WIDTH-1:0] fifo_addrB,
   output logic [LW-1:0]         fifo_dA,
   output logic [LW-1:0]         fifo_dB,
   output logic                  fifo_wr_enable,
   output logic                  fifo_wr_finish,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  poly_count,
   output logic                  err_last
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(POLY_LINES - 1);

   axis_wr_states         state, state_next;
   logic [ADDR_WIDTH-1:0] line_cnt;
   logic [LW-1:0]         hold;
   logic                  hs;
   logic                  last_line;

   always_ff @(posedge clk) begin
      if (rst) state <= WIDLE;
      else     state <= state_next;
   end

   // fifo_full is only consulted in IDLE; it cannot legally rise mid-poly
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      case (state)
         WIDLE: if (s_valid && !fifo_full) state_next = WFILL;
         WFILL: begin
            s_ready = 1'b1;
            if (s_valid && line_cnt == LAST_IDX) state_next = WLAST;
         end
         WLAST:   state_next = WDONE;
         WDONE:   state_next = WIDLE;
         default: state_next = WIDLE;
      endcase
   end

   assign hs        = s_valid && s_ready;
   assign last_line = (line_cnt == LAST_IDX);
   assign busy      = (state != WIDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         line_cnt       <= '0;
         hold           <= '0;
         fifo_addrA     <= '0;
         fifo_addrB     <= '0;
         fifo_dA        <= '0;
         fifo_dB        <= '0;
         fifo_wr_enable <= 1'b0;
         fifo_wr_finish <= 1'b1;
         poly_count     <= '0;
         err_last       <= 1'b0;
      end else begin
         fifo_wr_enable <= 1'b0;
         // finish is high exactly in DONE and IDLE, so the pointer advances once per poly
         fifo_wr_finish <= (state_next == WIDLE) || (state_next == WDONE);
         if (hs) begin
            line_cnt <= line_cnt + ADDR_WIDTH'(1);
            if (!line_cnt[0]) begin
               hold <= s_data;
            end else begin
               fifo_wr_enable <= 1'b1;
               fifo_addrA     <= {line_cnt[ADDR_WIDTH-1:1], 1'b0};
               fifo_addrB     <= line_cnt;
               fifo_dA        <= hold;
               fifo_dB        <= s_data;
            end
            if (s_last != last_line) err_last <= 1'b1;
         end
         if (state == WDONE) begin
            poly_count <= poly_count + CNT_WIDTH'(1);
            line_cnt   <= '0;
         end
      end
   end

endmodule
